// File: rtl/bpm_test_link_pkg.sv
// Shared definitions for the BPM test-link writer and reader: frame layout,
// header field positions, payload pattern constants and the reader state type.
package bpm_test_link_pkg;

  localparam int unsigned FRAME_WORDS = 4;
  localparam logic [1:0]  LAST_WORD   = 2'(FRAME_WORDS - 1);

  localparam logic [2:0]  HDR_MARKER  = 3'b101;
  localparam logic [15:0] PAT_WORD1   = 16'hA5A5;
  localparam logic [15:0] PAT_WORD2   = 16'h5A5A;

  localparam int unsigned HDR_MARKER_MSB = 31;
  localparam int unsigned HDR_MARKER_LSB = 29;
  localparam int unsigned HDR_INDEX_MSB  = 28;
  localparam int unsigned HDR_INDEX_LSB  = 24;
  localparam int unsigned HDR_RSVD_MSB   = 23;
  localparam int unsigned HDR_RSVD_LSB   = 16;
  localparam int unsigned HDR_SEQ_MSB    = 15;
  localparam int unsigned HDR_SEQ_LSB    = 0;

  typedef enum logic [1:0] {
    StIdle,
    StPayload,
    StDiscard
  } link_state_e;

  // Payload word expected at position cnt (1..3) of a frame carrying seq.
  function automatic logic [31:0] expected_word(input logic [15:0] seq, input logic [1:0] cnt);
    logic [31:0] w;
    case (cnt)
      2'd1:    w = {PAT_WORD1, seq};
      2'd2:    w = {PAT_WORD2, ~seq};
      2'd3:    w = {seq, seq};
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/bpm_test_link_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats a coincident increment.
module bpm_test_link_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/read_bpm_test_link.sv
// Receive-side BPM test-link frame checker with saturating error/frame counters.
// Define BPM_TEST_LINK_PATTERN_CHECK_EN to build the payload pattern comparison.
module read_bpm_test_link
  import bpm_test_link_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH       = 16,
  parameter int unsigned FRAME_COUNT_WIDTH = 32
) (
  input  logic                         auroraUserClk,
  input  logic                         auroraReset,
  input  logic                         auroraChannelUp,
  input  logic                         clearCounters,
  input  logic [4:0]                   expectedBPMindex,
  input  logic [31:0]                  BPM_TEST_AXI_STREAM_RX_tdata,
  input  logic                         BPM_TEST_AXI_STREAM_RX_tvalid,
  input  logic                         BPM_TEST_AXI_STREAM_RX_tlast,
  output logic                         frameStrobe,
  output logic [FRAME_COUNT_WIDTH-1:0] frameCount,
  output logic [COUNT_WIDTH-1:0]       seqErrCount,
  output logic [COUNT_WIDTH-1:0]       lenErrCount,
  output logic [COUNT_WIDTH-1:0]       hdrErrCount,
  output logic [COUNT_WIDTH-1:0]       dataErrCount,
  output logic [15:0]                  lastSeq,
  output logic [4:0]                   lastBPMindex
);

  logic        clk;
  logic        rst;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;

  assign clk    = auroraUserClk;
  assign rst    = auroraReset;
  assign tdata  = BPM_TEST_AXI_STREAM_RX_tdata;
  assign tvalid = BPM_TEST_AXI_STREAM_RX_tvalid;
  assign tlast  = BPM_TEST_AXI_STREAM_RX_tlast;

  logic unused_reserved;
  assign unused_reserved = ^tdata[HDR_RSVD_MSB:HDR_RSVD_LSB];

  link_state_e state_q, state_d;
  logic [1:0]  word_cnt_q, word_cnt_d;
  logic [15:0] seq_q, seq_d;
  logic [4:0]  idx_q, idx_d;
  logic        hdr_ok;

  logic ev_good, ev_len, ev_hdr;
  logic pend_good_q, pend_len_q, pend_hdr_q;
  logic [15:0] pend_seq_q;
  logic [4:0]  pend_idx_q;

  assign hdr_ok = (tdata[HDR_MARKER_MSB:HDR_MARKER_LSB] == HDR_MARKER) &&
                  (tdata[HDR_INDEX_MSB:HDR_INDEX_LSB] == expectedBPMindex);

`ifdef BPM_TEST_LINK_PATTERN_CHECK_EN
  logic data_bad_q, data_bad_d;
  logic word_mismatch;
  logic ev_data;
  logic pend_data_q;

  assign word_mismatch = (tdata != expected_word(seq_q, word_cnt_q));
`endif

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    seq_d      = seq_q;
    idx_d      = idx_q;
    ev_good    = 1'b0;
    ev_len     = 1'b0;
    ev_hdr     = 1'b0;
`ifdef BPM_TEST_LINK_PATTERN_CHECK_EN
    data_bad_d = data_bad_q;
    ev_data    = 1'b0;
`endif
    if (!auroraChannelUp) begin
      state_d    = StIdle;
      word_cnt_d = '0;
    end else if (tvalid) begin
      unique case (state_q)
        StIdle: begin
          // Header faults outrank the single-beat length fault.
          if (!hdr_ok) begin
            ev_hdr  = 1'b1;
            state_d = tlast ? StIdle : StDiscard;
          end else if (tlast) begin
            ev_len = 1'b1;
          end else begin
            seq_d      = tdata[HDR_SEQ_MSB:HDR_SEQ_LSB];
            idx_d      = tdata[HDR_INDEX_MSB:HDR_INDEX_LSB];
            word_cnt_d = 2'd1;
            state_d    = StPayload;
`ifdef BPM_TEST_LINK_PATTERN_CHECK_EN
            data_bad_d = 1'b0;
`endif
          end
        end
        StPayload: begin
`ifdef BPM_TEST_LINK_PATTERN_CHECK_EN
          data_bad_d = data_bad_q | word_mismatch;
`endif
          if (word_cnt_q != LAST_WORD) begin
            if (tlast) begin
              ev_len     = 1'b1;
              word_cnt_d = '0;
              state_d    = StIdle;
            end else begin
              word_cnt_d = word_cnt_q + 2'd1;
            end
          end else if (!tlast) begin
            ev_len     = 1'b1;
            word_cnt_d = '0;
            state_d    = StDiscard;
          end else begin
            word_cnt_d = '0;
            state_d    = StIdle;
`ifdef BPM_TEST_LINK_PATTERN_CHECK_EN
            if (data_bad_q | word_mismatch) ev_data = 1'b1;
            else                            ev_good = 1'b1;
`else
            ev_good = 1'b1;
`endif
          end
        end
        StDiscard: begin
          if (tlast) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      word_cnt_q  <= '0;
      seq_q       <= '0;
      idx_q       <= '0;
      pend_good_q <= 1'b0;
      pend_len_q  <= 1'b0;
      pend_hdr_q  <= 1'b0;
      pend_seq_q  <= '0;
      pend_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      seq_q       <= seq_d;
      idx_q       <= idx_d;
      pend_good_q <= ev_good;
      pend_len_q  <= ev_len;
      pend_hdr_q  <= ev_hdr;
      if (ev_good) begin
        pend_seq_q <= seq_q;
        pend_idx_q <= idx_q;
      end
    end
  end

`ifdef BPM_TEST_LINK_PATTERN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_bad_q  <= 1'b0;
      pend_data_q <= 1'b0;
    end else begin
      data_bad_q  <= auroraChannelUp ? data_bad_d : 1'b0;
      pend_data_q <= ev_data;
    end
  end
`endif

  // Second stage: commit the completed frame one cycle after its tlast beat.
  logic        seq_synced_q, seq_synced_d;
  logic [15:0] prev_seq_q;
  logic        seq_err_inc;
  logic        frame_strobe_q;
  logic [15:0] last_seq_q;
  logic [4:0]  last_idx_q;

  assign seq_err_inc = pend_good_q && seq_synced_q && (pend_seq_q != 16'(prev_seq_q + 16'd1));

  always_comb begin
    seq_synced_d = seq_synced_q;
    if (!auroraChannelUp || clearCounters) seq_synced_d = 1'b0;
    else if (pend_good_q)                  seq_synced_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_synced_q   <= 1'b0;
      prev_seq_q     <= '0;
      frame_strobe_q <= 1'b0;
      last_seq_q     <= '0;
      last_idx_q     <= '0;
    end else begin
      seq_synced_q   <= seq_synced_d;
      frame_strobe_q <= pend_good_q;
      if (pend_good_q) begin
        prev_seq_q <= pend_seq_q;
        last_seq_q <= pend_seq_q;
        last_idx_q <= pend_idx_q;
      end
    end
  end

  assign frameStrobe  = frame_strobe_q;
  assign lastSeq      = last_seq_q;
  assign lastBPMindex = last_idx_q;

  bpm_test_link_sat_counter #(.WIDTH(FRAME_COUNT_WIDTH)) u_frame_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pend_good_q),
    .clear (clearCounters),
    .count (frameCount)
  );

  bpm_test_link_sat_counter #(.WIDTH(COUNT_WIDTH)) u_seq_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (seq_err_inc),
    .clear (clearCounters),
    .count (seqErrCount)
  );

  bpm_test_link_sat_counter #(.WIDTH(COUNT_WIDTH)) u_len_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pend_len_q),
    .clear (clearCounters),
    .count (lenErrCount)
  );

  bpm_test_link_sat_counter #(.WIDTH(COUNT_WIDTH)) u_hdr_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pend_hdr_q),
    .clear (clearCounters),
    .count (hdrErrCount)
  );

`ifdef BPM_TEST_LINK_PATTERN_CHECK_EN
  bpm_test_link_sat_counter #(.WIDTH(COUNT_WIDTH)) u_data_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pend_data_q),
    .clear (clearCounters),
    .count (dataErrCount)
  );
`else
  assign dataErrCount = '0;
`endif

endmodule

// File: tb/tb_read_bpm_test_link.sv
// Directed self-checking bench for read_bpm_test_link; expectations are hand-derived.
module tb_read_bpm_test_link;

  logic        clk = 1'b0;
  logic        rst;
  logic        chan_up;
  logic        clr;
  logic [4:0]  exp_idx;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        frame_strobe;
  logic [31:0] frame_count;
  logic [15:0] seq_err, len_err, hdr_err, data_err;
  logic [15:0] last_seq;
  logic [4:0]  last_idx;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  int strobe_base;

  always #5 clk = ~clk;

  read_bpm_test_link #(
    .COUNT_WIDTH       (16),
    .FRAME_COUNT_WIDTH (32)
  ) dut (
    .auroraUserClk                 (clk),
    .auroraReset                   (rst),
    .auroraChannelUp               (chan_up),
    .clearCounters                 (clr),
    .expectedBPMindex              (exp_idx),
    .BPM_TEST_AXI_STREAM_RX_tdata  (tdata),
    .BPM_TEST_AXI_STREAM_RX_tvalid (tvalid),
    .BPM_TEST_AXI_STREAM_RX_tlast  (tlast),
    .frameStrobe                   (frame_strobe),
    .frameCount                    (frame_count),
    .seqErrCount                   (seq_err),
    .lenErrCount                   (len_err),
    .hdrErrCount                   (hdr_err),
    .dataErrCount                  (data_err),
    .lastSeq                       (last_seq),
    .lastBPMindex                  (last_idx)
  );

  always @(negedge clk) if (frame_strobe === 1'b1) strobe_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic l);
    tvalid = 1'b1;
    tdata  = d;
    tlast  = l;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0;
    tlast  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // bad_word < 0 means no corruption; gap inserts one tvalid-low cycle after each beat.
  task automatic send_frame(input logic [15:0] s, input int nwords, input logic [2:0] mk,
                            input logic [4:0] ix, input int bad_word, input int gap);
    logic [31:0] w;
    for (int i = 0; i < nwords; i++) begin
      case (i)
        0:       w = {mk, ix, 8'h00, s};
        1:       w = {16'hA5A5, s};
        2:       w = {16'h5A5A, ~s};
        3:       w = {s, s};
        default: w = 32'hDEAD_BEEF;
      endcase
      if (i == bad_word) w = w ^ 32'h0000_0100;
      drive_beat(w, i == nwords - 1);
      if (gap != 0 && i != nwords - 1) idle(1);
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic good(input logic [15:0] s);
    send_frame(s, 4, 3'b101, 5'd1, -1, 0);
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    chan_up = 1'b0;
    clr     = 1'b0;
    exp_idx = 5'd1;
    tdata   = '0;
    tvalid  = 1'b0;
    tlast   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check_eq("rst_strobe", {31'd0, frame_strobe}, 32'd0);
    check_eq("rst_frames", frame_count, 32'd0);
    check_eq("rst_errs", {seq_err, len_err}, 32'd0);
    check_eq("rst_errs2", {hdr_err, data_err}, 32'd0);
    check_eq("rst_last", {11'd0, last_idx, last_seq}, 32'd0);

    // Ten back-to-back good frames.
    chan_up = 1'b1;
    @(negedge clk);
    strobe_base = strobe_cnt;
    for (int i = 0; i < 10; i++) good(16'(i));
    idle(3);
    check_eq("b2b_frames", frame_count, 32'd10);
    check_eq("b2b_strobes", 32'(strobe_cnt - strobe_base), 32'd10);
    check_eq("b2b_seqlen", {seq_err, len_err}, 32'd0);
    check_eq("b2b_hdrdata", {hdr_err, data_err}, 32'd0);
    check_eq("b2b_last_seq", {16'd0, last_seq}, 32'd9);
    check_eq("b2b_last_idx", {27'd0, last_idx}, 32'd1);

    // Sequence gap and wrap.
    pulse_clear();
    check_eq("clr_frames", frame_count, 32'd0);
    good(16'd5); good(16'd6); good(16'd8); good(16'd9);
    idle(3);
    check_eq("gap_seq_err", {16'd0, seq_err}, 32'd1);
    check_eq("gap_frames", frame_count, 32'd4);
    pulse_clear();
    good(16'hFFFF); good(16'h0000);
    idle(3);
    check_eq("wrap_seq_err", {16'd0, seq_err}, 32'd0);
    check_eq("wrap_frames", frame_count, 32'd2);
    check_eq("wrap_last_seq", {16'd0, last_seq}, 32'h0000);

    // Short and long frames, then good frames (one with tvalid gaps).
    pulse_clear();
    send_frame(16'd1, 3, 3'b101, 5'd1, -1, 0);
    send_frame(16'd2, 5, 3'b101, 5'd1, -1, 0);
    good(16'd50);
    send_frame(16'd51, 4, 3'b101, 5'd1, -1, 1);
    idle(3);
    check_eq("len_len_err", {16'd0, len_err}, 32'd2);
    check_eq("len_frames", frame_count, 32'd2);
    check_eq("len_seq_err", {16'd0, seq_err}, 32'd0);
    check_eq("len_last_seq", {16'd0, last_seq}, 32'd51);

    // Header faults and payload corruption.
    pulse_clear();
    send_frame(16'd3, 4, 3'b100, 5'd1, -1, 0);
    send_frame(16'd4, 4, 3'b101, 5'd2, -1, 0);
    send_frame(16'd7, 4, 3'b101, 5'd1, 2, 0);
    idle(3);
    check_eq("hdr_hdr_err", {16'd0, hdr_err}, 32'd2);
    check_eq("hdr_len_err", {16'd0, len_err}, 32'd0);
`ifdef BPM_TEST_LINK_PATTERN_CHECK_EN
    check_eq("data_err", {16'd0, data_err}, 32'd1);
    check_eq("data_frames", frame_count, 32'd0);
`else
    check_eq("data_err", {16'd0, data_err}, 32'd0);
    check_eq("data_frames", frame_count, 32'd1);
`endif

    // Channel drop mid-frame, resume with an unrelated sequence number.
    pulse_clear();
    good(16'd10);
    drive_beat({3'b101, 5'd1, 8'h00, 16'd11}, 1'b0);
    drive_beat({16'hA5A5, 16'd11}, 1'b0);
    chan_up = 1'b0;
    drive_beat({16'h5A5A, ~16'd11}, 1'b0);
    drive_beat({16'd11, 16'd11}, 1'b1);
    idle(3);
    chan_up = 1'b1;
    good(16'h1234);
    idle(3);
    check_eq("drop_len_err", {16'd0, len_err}, 32'd0);
    check_eq("drop_seq_err", {16'd0, seq_err}, 32'd0);
    check_eq("drop_frames", frame_count, 32'd2);
    check_eq("drop_last_seq", {16'd0, last_seq}, 32'h1234);

    // Clear on the same cycle the completed frame would be counted.
    good(16'h1235);
    pulse_clear();
    idle(2);
    check_eq("clrwin_frames", frame_count, 32'd0);

    // Saturation of the length-error counter.
    tvalid = 1'b1;
    tlast  = 1'b1;
    tdata  = {3'b101, 5'd1, 8'h00, 16'h0000};
    repeat (65534) @(negedge clk);
    idle(2);
    check_eq("sat_below", {16'd0, len_err}, 32'h0000_FFFE);
    tvalid = 1'b1;
    tlast  = 1'b1;
    repeat (6) @(negedge clk);
    idle(2);
    check_eq("sat_hold", {16'd0, len_err}, 32'h0000_FFFF);
    check_eq("sat_frames", frame_count, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/read_bpm_test_link.md
# read_bpm_test_link

Receive-side checker for the BPM test link. Sits on the Aurora user-clock side and consumes the AXI-Stream RX frames produced by the BPM test-link writer at the far end. Parses and validates each frame (header marker, BPM index, sequence continuity, length, payload pattern) and maintains saturating error/frame counters plus the last good readback for CSR export. Clock-domain crossing to sysClk is outside this block.

## Interface
- COUNT_WIDTH, 16, width of each error counter
- FRAME_COUNT_WIDTH, 32, width of good-frame counter

- auroraUserClk  in  1  sole clock
- auroraReset  in  1  asynchronous, active-high reset
- auroraChannelUp  in  1  Aurora channel status; low forces resync
- clearCounters  in  1  single-cycle pulse, zeroes all counters
- expectedBPMindex  in  5  BPM index the header must carry
- BPM_TEST_AXI_STREAM_RX_tdata  in  32  stream data
- BPM_TEST_AXI_STREAM_RX_tvalid  in  1  beat valid (no tready; Aurora RX cannot be stalled)
- BPM_TEST_AXI_STREAM_RX_tlast  in  1  last beat of frame
- frameStrobe  out  1  one-cycle pulse per good frame
- frameCount  out  FRAME_COUNT_WIDTH  good frames received
- seqErrCount  out  COUNT_WIDTH  sequence discontinuities
- lenErrCount  out  COUNT_WIDTH  frames of wrong length
- hdrErrCount  out  COUNT_WIDTH  bad marker or BPM index
- dataErrCount  out  COUNT_WIDTH  payload pattern mismatches
- lastSeq  out  16  sequence number of last good frame
- lastBPMindex  out  5  BPM index of last good frame

## Operation
- Frame = 4 words, tlast on word 3. Word 0 header: [31:29]=3'b101 marker, [28:24] BPM index, [23:16] reserved, [15:0] seq. Word 1 = {16'hA5A5, seq}; word 2 = {16'h5A5A, ~seq}; word 3 = {seq, seq}.
- States: IDLE (expect header), PAYLOAD (words 1..3, wordCnt), DISCARD (drop until tlast).
- IDLE, valid beat: tlast set → lenErr, stay IDLE. Marker or index wrong → hdrErr, DISCARD (or IDLE if tlast). Otherwise latch seq, wordCnt=1, PAYLOAD.
- PAYLOAD, valid beat: compare against expected word; mismatch sets per-frame dataBad flag. tlast with wordCnt<3 → lenErr, IDLE. wordCnt==3 without tlast → lenErr, DISCARD. wordCnt==3 with tlast → frame complete, IDLE.
- Frame complete: dataBad → dataErr only (frame not good). Else good: frameCount++, frameStrobe, lastSeq/lastBPMindex updated, sequence check.
- Sequence check: seqSynced clear after reset, clearCounters, or auroraChannelUp low; first good frame sets seqSynced, no check. Thereafter seq ≠ prevSeq+1 (mod 2^16) → seqErr++, resync to received seq. 0xFFFF→0x0000 is continuous.
- Only one error counted per frame; precedence hdr > len > data > seq.
- auroraChannelUp low: state→IDLE, wordCnt→0, seqSynced→0, beats ignored; counters hold.
- All counters saturate at all-ones.

## Timing
- Reset: all outputs 0, state IDLE, seqSynced 0.
- Counters, frameStrobe, lastSeq, lastBPMindex update on the clock edge after the tlast beat is sampled (1-cycle latency).
- Back-to-back frames (header on cycle after tlast) accepted without gap.
- tvalid low beats are ignored at any state; no timeouts.
- clearCounters coincident with an increment: clear wins, result 0.
- Asynchronous reset mid-frame: immediate return to reset state; partial frame discarded without error.

## Configuration
- BPM_TEST_LINK_PATTERN_CHECK_EN defined: payload words 1..3 compared as above; dataErrCount active.
- Not defined: payload ignored (only length, header, sequence checked); dataErrCount tied to 0; compare logic not built.

## Structure
- Package bpm_test_link_pkg: FRAME_WORDS=4, HDR_MARKER=3'b101, pattern constants 16'hA5A5/16'h5A5A, header field bit positions, state enum. Shared with the writer.
- One sub-module: bpm_test_link_sat_counter (parameterized width, inc, clear, clear-wins, saturating), instantiated five times.

## Test plan
- Reset, channel up, 10 good frames seq 0..9, index 1 → frameCount=10, all error counts 0, lastSeq=9, 10 frameStrobe pulses.
- Good frames seq 5,6,8,9 → seqErrCount=1, frameCount=4; seq 0xFFFF then 0x0000 → no seqErr.
- 3-word frame, then 5-word frame, then good frame → lenErrCount=2, frameCount=1, good frame seq not flagged (resync behaviour verified).
- Header marker 3'b100, then index 2 with expectedBPMindex=1 → hdrErrCount=2; payload word 2 corrupted → dataErrCount=1 (0 with macro undefined).
- Drop auroraChannelUp mid-frame for 5 cycles, resume with arbitrary seq → no len/seq error, frame counted.
- clearCounters asserted on same cycle as frame-complete update → all counters 0; counters at 0xFFFF stay saturated on further errors.
